// File: rtl/alu_mdu_control_if.sv
// EX-stage bundle between the pipeline and the ALU-control / multiply-divide block.
// The master side drives the decoded instruction and operands. The slave side returns the control code, stall and result.
interface alu_mdu_control_if #(
    parameter int XLEN = 32
);
    logic            valid_in;
    logic            flush;
    logic [1:0]      ALUOp;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [3:0]      alu_control;
    logic            is_mdu;
    logic            stall;
    logic [XLEN-1:0] mdu_result;
    logic            mdu_valid;

    modport master (
        output valid_in, flush, ALUOp, funct3, funct7, op_a, op_b,
        input  alu_control, is_mdu, stall, mdu_result, mdu_valid
    );

    modport slave (
        input  valid_in, flush, ALUOp, funct3, funct7, op_a, op_b,
        output alu_control, is_mdu, stall, mdu_result, mdu_valid
    );
endinterface

// File: rtl/alu_mdu_control.sv
// RV32 ALU-control decoder plus an iterative M-extension unit (shift-add multiply, restoring divide).
// Latency: decode is combinational. An M-op takes XLEN+1 edges to DONE, or 1 edge for divide special cases.
// Backpressure: stall holds IF/ID/EX from accept until DONE.
module alu_mdu_control #(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1,
    parameter int CNT_W    = $clog2(XLEN) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_mdu_control_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] acc, acc_nxt;
    logic [XLEN-1:0]   opb_q;
    logic [2:0]        fn3_q;
    logic              neg_q;

    logic              accept, special, last_iter;
    logic              sgn_a, sgn_b, div_zero, div_ovf;
    logic [XLEN-1:0]   abs_a, abs_b, special_res;
    logic [XLEN:0]     mul_sum, div_hi;
    logic [XLEN-1:0]   div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   q_raw, r_raw, final_res;

    // ALU-control decode; M-ops park the ALU on ADD since its result is not used
    always_comb begin
        bus.is_mdu      = ENABLE_M && (bus.ALUOp == 2'b10) && (bus.funct7 == 7'b0000001);
        bus.alu_control = 4'b0000;
        case (bus.ALUOp)
            2'b00: bus.alu_control = 4'b0010;
            2'b01: begin
                case (bus.funct3)
                    3'b000, 3'b001: bus.alu_control = 4'b0110;
                    3'b100, 3'b101: bus.alu_control = 4'b0111;
                    3'b110, 3'b111: bus.alu_control = 4'b1010;
                    default:        bus.alu_control = 4'b0000;
                endcase
            end
            2'b10: begin
                if (bus.is_mdu) begin
                    bus.alu_control = 4'b0010;
                end else begin
                    case (bus.funct3)
                        3'b000:  bus.alu_control = bus.funct7[5] ? 4'b0110 : 4'b0010;
                        3'b001:  bus.alu_control = 4'b1001;
                        3'b010:  bus.alu_control = 4'b0111;
                        3'b011:  bus.alu_control = 4'b1010;
                        3'b100:  bus.alu_control = 4'b1000;
                        3'b101:  bus.alu_control = bus.funct7[5] ? 4'b1100 : 4'b1011;
                        3'b110:  bus.alu_control = 4'b0001;
                        default: bus.alu_control = 4'b0000;
                    endcase
                end
            end
            default: bus.alu_control = 4'b0000;
        endcase
    end

    // Operand conditioning at accept: MULH/MULHSU/DIV/REM see op_a as signed, MULH/DIV/REM also op_b
    always_comb begin
        sgn_a = ((bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                 (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110)) && bus.op_a[XLEN-1];
        sgn_b = ((bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                 (bus.funct3 == 3'b110)) && bus.op_b[XLEN-1];
        abs_a = sgn_a ? -bus.op_a : bus.op_a;
        abs_b = sgn_b ? -bus.op_b : bus.op_b;

        div_zero = (bus.op_b == '0);
        div_ovf  = !bus.funct3[0] && (bus.op_a == MIN_NEG) && (bus.op_b == '1);
        special  = bus.funct3[2] && (div_zero || div_ovf);
        if (div_zero)
            special_res = bus.funct3[1] ? bus.op_a : '1;
        else
            special_res = bus.funct3[1] ? '0 : bus.op_a;

        accept = rst_n && (state == IDLE) && bus.valid_in && bus.is_mdu && !bus.flush;
    end

    // One iteration step; acc holds {partial/remainder, multiplier/quotient}
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb_q} : '0);
        div_hi   = acc[2*XLEN-1:XLEN-1];
        div_ge   = (div_hi >= {1'b0, opb_q});
        div_diff = div_hi[XLEN-1:0] - opb_q;

        acc_nxt = acc;
        if (state == MUL)
            acc_nxt = {mul_sum, acc[XLEN-1:1]};
        else if (state == DIV)
            acc_nxt = {(div_ge ? div_diff : div_hi[XLEN-1:0]), acc[XLEN-2:0], div_ge};

        last_iter = (cnt == CNT_W'(XLEN - 1));

        prod_fix = neg_q ? -acc_nxt : acc_nxt;
        q_raw    = acc_nxt[XLEN-1:0];
        r_raw    = acc_nxt[2*XLEN-1:XLEN];
        case (fn3_q)
            3'b000:                 final_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_res = neg_q ? -q_raw : q_raw;
            default:                final_res = neg_q ? -r_raw : r_raw;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept)
                    state_nxt = special ? DONE : (bus.funct3[2] ? DIV : MUL);
            end
            MUL, DIV: begin
                if (bus.flush)
                    state_nxt = IDLE;
                else if (last_iter)
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase

        bus.stall     = accept || (state == MUL) || (state == DIV);
        bus.mdu_valid = (state == DONE) && !bus.flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            acc            <= '0;
            opb_q          <= '0;
            fn3_q          <= '0;
            neg_q          <= 1'b0;
            bus.mdu_result <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt   <= '0;
                fn3_q <= bus.funct3;
                acc   <= {{XLEN{1'b0}}, abs_a};
                opb_q <= abs_b;
                // remainder follows the dividend sign, everything else follows the product/quotient sign
                neg_q <= (bus.funct3[2] && bus.funct3[1]) ? sgn_a : (sgn_a ^ sgn_b);
                if (special)
                    bus.mdu_result <= special_res;
            end else if (((state == MUL) || (state == DIV)) && !bus.flush) begin
                acc <= acc_nxt;
                cnt <= cnt + CNT_W'(1);
                if (last_iter)
                    bus.mdu_result <= final_res;
            end
        end
    end
endmodule

// File: tb/tb_alu_mdu_control.sv
// Scoreboard bench: stimulus queues hand-computed results, a negedge monitor checks each mdu_valid pulse.
`timescale 1ns/1ps
module tb_alu_mdu_control;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_mdu_control_if #(.XLEN(32)) bus0 ();
    alu_mdu_control_if #(.XLEN(32)) bus1 ();

    alu_mdu_control #(.XLEN(32), .ENABLE_M(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    alu_mdu_control #(.XLEN(32), .ENABLE_M(1'b0)) dut_nom (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic [31:0] last_exp = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus0.mdu_valid === 1'b1) begin
            if (exp_q.size() == 0)
                chk("unexpected_mdu_valid", {31'd0, bus0.mdu_valid}, 32'd0);
            else
                chk(name_q.pop_front(), bus0.mdu_result, exp_q.pop_front());
        end
    end

    task automatic start(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        bus0.valid_in = 1'b1;
        bus0.ALUOp    = 2'b10;
        bus0.funct7   = 7'b0000001;
        bus0.funct3   = f3;
        bus0.op_a     = a;
        bus0.op_b     = b;
        #1 chk("accept_stall", {31'd0, bus0.stall}, 32'd1);
        @(posedge clk); #1;
        bus0.valid_in = 1'b0;
    endtask

    task automatic issue(input string nm, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] want, input int lat_exp);
        int lat;
        int stl;
        exp_q.push_back(want);
        name_q.push_back(nm);
        start(f3, a, b);
        lat = 1;
        stl = 0;
        while (bus0.mdu_valid !== 1'b1 && lat < 200) begin
            if (bus0.stall === 1'b1) stl++;
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_latency"}, 32'(lat), 32'(lat_exp));
        chk({nm, "_stall_cycles"}, 32'(stl), 32'(lat_exp - 1));
        chk({nm, "_done_stall"}, {31'd0, bus0.stall}, 32'd0);
        last_exp = want;
    endtask

    task automatic decode(input string nm, input logic [1:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [3:0] want);
        @(posedge clk); #1;
        bus0.valid_in = 1'b1;
        bus0.ALUOp    = op;
        bus0.funct3   = f3;
        bus0.funct7   = f7;
        #1;
        chk(nm, {28'd0, bus0.alu_control}, {28'd0, want});
        chk({nm, "_stall"}, {31'd0, bus0.stall}, 32'd0);
        bus0.valid_in = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        bus0.valid_in = 1'b0; bus0.flush = 1'b0; bus0.ALUOp = 2'b00;
        bus0.funct3 = 3'b000; bus0.funct7 = 7'b0; bus0.op_a = '0; bus0.op_b = '0;
        bus1.valid_in = 1'b0; bus1.flush = 1'b0; bus1.ALUOp = 2'b00;
        bus1.funct3 = 3'b000; bus1.funct7 = 7'b0; bus1.op_a = 32'd5; bus1.op_b = 32'd3;
        #2 rst_n = 1'b0;
        #20;
        chk("rst_result", bus0.mdu_result, 32'd0);
        chk("rst_valid", {31'd0, bus0.mdu_valid}, 32'd0);
        chk("rst_stall", {31'd0, bus0.stall}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        decode("dec_sra", 2'b10, 3'b101, 7'b0100000, 4'b1100);
        decode("dec_sub", 2'b10, 3'b000, 7'b0100000, 4'b0110);
        decode("dec_srl", 2'b10, 3'b101, 7'b0000000, 4'b1011);
        decode("dec_sltu", 2'b10, 3'b011, 7'b0000000, 4'b1010);
        decode("dec_br110", 2'b01, 3'b110, 7'b0000000, 4'b1010);
        decode("dec_br010", 2'b01, 3'b010, 7'b0000000, 4'b0000);
        decode("dec_op11", 2'b11, 3'b000, 7'b0000000, 4'b0000);
        decode("dec_op00", 2'b00, 3'b111, 7'b0100000, 4'b0010);

        @(posedge clk); #1;
        bus1.valid_in = 1'b1; bus1.ALUOp = 2'b10; bus1.funct3 = 3'b000; bus1.funct7 = 7'b0000001;
        #1;
        chk("nom_alu_control", {28'd0, bus1.alu_control}, 32'h2);
        chk("nom_is_mdu", {31'd0, bus1.is_mdu}, 32'd0);
        chk("nom_stall", {31'd0, bus1.stall}, 32'd0);
        repeat (3) @(posedge clk);
        #1 chk("nom_stall_later", {31'd0, bus1.stall}, 32'd0);
        bus1.valid_in = 1'b0;

        issue("mul",     3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        issue("mulh",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
        issue("mulhu",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        issue("mulhsu",  3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
        issue("mulh_m1", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
        issue("div",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
        issue("rem",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
        issue("rem_negb",3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001, 33);
        issue("remu",    3'b111, 32'd100,      32'd7,        32'd2,        33);
        issue("divu",    3'b101, 32'd100,      32'd7,        32'd14,       33);

        // divide flushed at iteration 10: no result, old result kept
        start(3'b101, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1 chk("flush_pre_stall", {31'd0, bus0.stall}, 32'd1);
        bus0.flush = 1'b1;
        @(posedge clk); #1;
        bus0.flush = 1'b0;
        chk("flush_stall", {31'd0, bus0.stall}, 32'd0);
        chk("flush_valid", {31'd0, bus0.mdu_valid}, 32'd0);
        chk("flush_result", bus0.mdu_result, last_exp);
        repeat (40) @(posedge clk);
        #1 chk("flush_result_late", bus0.mdu_result, last_exp);

        issue("div_by0",  3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        issue("remu_by0", 3'b111, 32'd5,        32'd0,        32'd5,        1);
        issue("div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        issue("rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

        // asynchronous reset in the middle of a multiply
        issue("mul_big", 3'b000, 32'h00012345, 32'h00001000, 32'h12345000, 33);
        start(3'b000, 32'd9, 32'd9);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_stall", {31'd0, bus0.stall}, 32'd0);
        chk("arst_valid", {31'd0, bus0.mdu_valid}, 32'd0);
        chk("arst_result", bus0.mdu_result, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1 chk("arst_no_result", bus0.mdu_result, 32'd0);

        issue("divu_after_rst", 3'b101, 32'hFFFFFFFF, 32'd16, 32'h0FFFFFFF, 33);

        repeat (3) @(posedge clk);
        #1 chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
